// File: rtl/req_arbiter_8.sv
// 8-way request arbiter: round-robin or fixed-priority selection, optional hold-time
// limit with a timeout pulse, and one forced dead cycle between consecutive grants.
module req_arbiter_8 #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned HOLD_W     = 4,
    parameter int unsigned MAX_HOLD   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    localparam bit LIMIT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LIMIT_EN ? MAX_HOLD - 32'd1 : 32'd0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;

    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_found;
    logic [IDX_W-1:0]    fp_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                limit_hit;
    logic                owner_req;

    // Winner selection: rotating scan starting after last owner, or highest index.
    always_comb begin
        cand     = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        fp_idx   = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_idx_q + IDX_W'(i);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                fp_idx = IDX_W'(i);
            end
        end
        win_idx = (FIXED_PRIO != 0) ? fp_idx : rr_idx;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_idx_d  = last_idx_q;

        limit_hit = LIMIT_EN && (hold_cnt_q == HOLD_LAST);
        owner_req = req[gnt_idx_q];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (done || !owner_req || limit_hit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    last_idx_d  = gnt_idx_q;
                    // Only a release caused purely by the hold limit is flagged.
                    timeout_d   = limit_hit && !done && owner_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_idx_q  <= IDX_W'(N - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
